frame_shift_tx: RTL and testbench
=================================

# frame_shift_tx

Serial frame transmitter that drives the strobe-qualified bit protocol our receive-side control FSM consumes. It sends one mandatory header word and then, optionally, FRAME_LEN payload words, MSB first. One bit is sent per strobe pulse, and the strobe returns low between bits. It sits between a parallel word source (valid/ready) and the serial pins, and is the transmit end of the same link.

## Interface
Parameters:
- WIDTH, 8 — bits per word (header and payload); must be ≥ 2.
- FRAME_LEN, 4 — payload words per frame when payload is requested; must be ≥ 1.
- DIV, 4 — Clk cycles per strobe phase (high and low each); must be ≥ 1.

Ports:
- Clk  in  1  — single clock; all state updates on the rising edge.
- Reset  in  1  — asynchronous, active-low reset.
- Start  in  1  — frame request, sampled only in IDLE.
- Header  in  WIDTH  — header word, captured when Start is accepted.
- Has_Payload  in  1  — captured with Start; 1 means FRAME_LEN payload words follow the header.
- Data_In  in  WIDTH  — payload word.
- Data_Valid  in  1  — payload word is valid.
- Data_Ready  out  1  — block accepts a payload word this cycle.
- Ser_Data  out  1  — serial bit, stable for the whole high phase of Ser_Strobe.
- Ser_Strobe  out  1  — bit strobe; the receiver samples while it is high.
- Busy  out  1  — a frame is in progress.
- Done  out  1  — one-cycle pulse when the frame completes.

## Operation
- Reset (Reset=0) forces all outputs to 0 immediately: Ser_Data, Ser_Strobe, Data_Ready, Busy, Done. It also puts the state in IDLE and clears all counters. A frame in flight is abandoned without a completing strobe.
- The states are IDLE, SHIFT_HI, SHIFT_LO, WAIT_DATA and DONE. Encoding is binary, 3 bits.
- IDLE: if Start=1, load the shift register with Header and latch Has_Payload. Set word count to 0, bit count to WIDTH-1 and the phase timer to 0, then go to SHIFT_HI.
- SHIFT_HI: Ser_Strobe=1 and Ser_Data=shift register MSB. After DIV cycles, go to SHIFT_LO.
- SHIFT_LO: Ser_Strobe=0 and Ser_Data holds the bit just sent. After DIV cycles:
  - If bit count > 0: shift left by 1, decrement bit count, go to SHIFT_HI.
  - Else, if the word just sent was the header and Has_Payload=0: go to DONE.
  - Else, if word count = FRAME_LEN: go to DONE.
  - Else: go to WAIT_DATA.
- WAIT_DATA: Data_Ready=1 and Ser_Strobe=0. On Data_Valid=1, load Data_In, increment word count, reset bit count and the timer, and go to SHIFT_HI. With Data_Valid=0, the block stalls indefinitely with no strobe activity.
- DONE: Done=1 for exactly one cycle, then go to IDLE.
- Busy=1 in every state except IDLE.
- Start is ignored while Busy=1. Header and Has_Payload changes are ignored after capture.
- Data_Valid outside WAIT_DATA is ignored; Data_Ready is 0 there.
- Word count is $clog2(FRAME_LEN+1) bits, bit count is $clog2(WIDTH) bits and the timer is $clog2(DIV) bits, minimum 1 bit each. No counter wraps in legal operation.

## Timing
- All outputs are registered and change only on a rising Clk edge, except on asynchronous reset assertion.
- Start sampled at edge k: from edge k, Ser_Strobe=1, Ser_Data=Header[WIDTH-1] and Busy=1.
- Each bit occupies 2·DIV cycles: DIV high, then DIV low. Ser_Data changes only on the edge where Ser_Strobe rises.
- A word takes 2·DIV·WIDTH cycles.
- Header-only frame: DONE is entered at edge k+2·DIV·WIDTH, and Done is high for that one cycle. Busy falls one edge later.
- Payload handshake at edge j: Ser_Strobe=1 with Data_In[WIDTH-1] from edge j.
- With Data_Valid held at 1, the gap between words is exactly 1 cycle, spent in WAIT_DATA.
- Start may be asserted in the cycle after Done; it is accepted because the state is IDLE.
- Reset released mid-frame: the block resumes in IDLE and needs a fresh Start.

## Structure
- A shared package holds the state localparams (ST_IDLE … ST_DONE) and the 3-bit state width constant.
- One sub-module, strobe_timer: a DIV-cycle phase counter with a clear input and a terminal-count output. The top FSM instantiates it once.
- The shift register, bit counter and word counter stay in the top module.

## Test plan
All scenarios use WIDTH=8, DIV=2, FRAME_LEN=2.
- Header-only frame: Start with Header=0xA5, Has_Payload=0 → 8 strobes, each 2 cycles high and 2 low. Bits 1,0,1,0,0,1,0,1. Done pulses at k+32, and Busy=0 from k+33.
- Full frame: Header=0x3C, Has_Payload=1, Data_Valid held at 1 with words 0xFF then 0x01 → 24 strobes total. A 1-cycle Data_Ready gap occurs after the header and after the first payload word. Done pulses once.
- Stall: hold Data_Valid=0 for 50 cycles in WAIT_DATA → Ser_Strobe stays 0 and Data_Ready stays 1. Sending resumes on the handshake edge with no bit lost.
- Start while busy: pulse Start mid-header with Header=0x00 → ignored. The original header bits are unchanged, and only one Done pulse occurs.
- Reset mid-frame: deassert Reset during the 3rd strobe high phase → Ser_Strobe=0 and Busy=0 immediately. After release, the block stays idle until a new Start.
- Back-to-back frames: Start asserted in the cycle after Done → the new frame's strobe rises at the next edge.

Source files
------------

// File: rtl/frame_shift_tx_pkg.sv
// Shared definitions for the serial frame transmitter: FSM state encoding
// and a counter-width helper used by the top and the phase timer.
package frame_shift_tx_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT_HI  = 3'd1,
        ST_SHIFT_LO  = 3'd2,
        ST_WAIT_DATA = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_shift_tx_if.sv
// Parallel-side and serial-side signals of the frame transmitter, grouped
// so the word source and the transmitter share one bundle.
interface frame_shift_tx_if #(
    parameter int WIDTH = 8
);
    logic             Start;
    logic [WIDTH-1:0] Header;
    logic             Has_Payload;
    logic [WIDTH-1:0] Data_In;
    logic             Data_Valid;
    logic             Data_Ready;
    logic             Ser_Data;
    logic             Ser_Strobe;
    logic             Busy;
    logic             Done;

    // Frame requester / word source side.
    modport master (
        output Start, Header, Has_Payload, Data_In, Data_Valid,
        input  Data_Ready, Ser_Data, Ser_Strobe, Busy, Done
    );

    // Transmitter side.
    modport slave (
        input  Start, Header, Has_Payload, Data_In, Data_Valid,
        output Data_Ready, Ser_Data, Ser_Strobe, Busy, Done
    );
endinterface

// File: rtl/frame_shift_tx_strobe_timer.sv
// Phase timer for the strobe: counts DIV cycles per phase and flags the
// last cycle of each phase. Held at zero while clear is asserted.
module strobe_timer
    import frame_shift_tx_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tc
);

    localparam int                  TIMER_W = cnt_width(DIV);
    localparam logic [TIMER_W-1:0]  LAST    = TIMER_W'(DIV - 1);

    logic [TIMER_W-1:0] count;

    // Count within a phase, wrapping to zero on the terminal cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: flops take non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            count <= '0;
        end else if (clear || tc) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/frame_shift_tx.sv
// Serial frame transmitter: sends a header word and optionally FRAME_LEN
// payload words MSB first, one bit per strobe pulse (DIV cycles high, DIV
// cycles low). Payload words arrive over a valid/ready handshake.
module frame_shift_tx
    import frame_shift_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int DIV       = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    frame_shift_tx_if.slave    bus
);

    localparam int                 BIT_W     = cnt_width(WIDTH);
    localparam int                 WORD_W    = cnt_width(FRAME_LEN + 1);
    localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(WIDTH - 1);
    localparam logic [WORD_W-1:0]  WORD_LAST = WORD_W'(FRAME_LEN);

    state_t              state;
    logic [WIDTH-1:0]    shift_reg;
    logic [BIT_W-1:0]    bit_cnt;
    logic [WORD_W-1:0]   word_cnt;
    logic                has_payload;
    logic                ser_strobe;
    logic                data_ready;
    logic                busy;
    logic                done;

    logic                timer_clear;
    logic                phase_end;

    // The phase timer only runs while a bit is on the wire.
    assign timer_clear = !((state == ST_SHIFT_HI) || (state == ST_SHIFT_LO));

    strobe_timer #(
        .DIV (DIV)
    ) u_timer (
        .clk   (Clk),
        .rst_n (Reset),
        .clear (timer_clear),
        .tc    (phase_end)
    );

    // Frame sequencing: state, shift register, counters and registered outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            has_payload <= 1'b0;
            ser_strobe  <= 1'b0;
            data_ready  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.Start) begin
                        shift_reg   <= bus.Header;
                        has_payload <= bus.Has_Payload;
                        word_cnt    <= '0;
                        bit_cnt     <= BIT_LAST;
                        ser_strobe  <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ST_SHIFT_HI;
                    end
                end

                ST_SHIFT_HI: begin
                    if (phase_end) begin
                        ser_strobe <= 1'b0;
                        state      <= ST_SHIFT_LO;
                    end
                end

                ST_SHIFT_LO: begin
                    if (phase_end) begin
                        if (bit_cnt != '0) begin
                            // Next bit becomes the MSB as the strobe rises.
                            shift_reg  <= {shift_reg[WIDTH-2:0], 1'b0};
                            bit_cnt    <= bit_cnt - 1'b1;
                            ser_strobe <= 1'b1;
                            state      <= ST_SHIFT_HI;
                        end else if (((word_cnt == '0) && !has_payload) ||
                                     (word_cnt == WORD_LAST)) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            data_ready <= 1'b1;
                            state      <= ST_WAIT_DATA;
                        end
                    end
                end

                ST_WAIT_DATA: begin
                    if (bus.Data_Valid) begin
                        shift_reg  <= bus.Data_In;
                        word_cnt   <= word_cnt + 1'b1;
                        bit_cnt    <= BIT_LAST;
                        ser_strobe <= 1'b1;
                        data_ready <= 1'b0;
                        state      <= ST_SHIFT_HI;
                    end
                end

                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The shift register MSB is the serial bit; it only changes when a new
    // bit is loaded, which is always the edge where the strobe rises.
    assign bus.Ser_Data   = shift_reg[WIDTH-1];
    assign bus.Ser_Strobe = ser_strobe;
    assign bus.Data_Ready = data_ready;
    assign bus.Busy       = busy;
    assign bus.Done       = done;

endmodule

// File: tb/tb_frame_shift_tx.sv
// Bench for frame_shift_tx (WIDTH=8, DIV=2, FRAME_LEN=2). A frame-level model
// expands each frame into its expected per-cycle output trace; one compare
// process checks the DUT against that trace every cycle, and a monitor
// collects bits at strobe rises for word-level checks.
module tb_frame_shift_tx;

    localparam int W        = 8;
    localparam int FL       = 2;
    localparam int DIV      = 2;
    localparam int WORD_CYC = 2 * DIV * W;

    typedef struct packed {
        logic strobe;
        logic data;
        logic ready;
        logic busy;
        logic done;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;

    frame_shift_tx_if #(.WIDTH(W)) bus ();

    frame_shift_tx #(
        .WIDTH     (W),
        .FRAME_LEN (FL),
        .DIV       (DIV)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic last_data = 1'b0;
    logic rx_q[$];
    int   done_cnt = 0;
    logic prev_strobe = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
        end
    endtask

    // Expand a frame into the output trace it must produce, starting at the
    // Start edge. gap[i] is the number of extra stall cycles before payload
    // word i is handed over.
    function automatic void build_frame(input logic [W-1:0] hdr, input logic has_pl,
                                        input logic [W-1:0] pl [FL], input int gap [FL],
                                        output exp_t q[$]);
        logic [W-1:0] words[$];
        q = {};
        words.push_back(hdr);
        if (has_pl) for (int i = 0; i < FL; i++) words.push_back(pl[i]);
        for (int i = 0; i < words.size(); i++) begin
            for (int b = W - 1; b >= 0; b--) begin
                repeat (DIV) q.push_back(exp_t'{1'b1, words[i][b], 1'b0, 1'b1, 1'b0});
                repeat (DIV) q.push_back(exp_t'{1'b0, words[i][b], 1'b0, 1'b1, 1'b0});
            end
            if (i < words.size() - 1)
                repeat (1 + gap[i]) q.push_back(exp_t'{1'b0, words[i][0], 1'b1, 1'b1, 1'b0});
        end
        q.push_back(exp_t'{1'b0, words[words.size()-1][0], 1'b0, 1'b1, 1'b1});
    endfunction

    // Per-cycle compare against the model trace, plus the bit/done monitor.
    always @(posedge Clk) begin
        exp_t e;
        exp_t a;
        #1;
        a = exp_t'{bus.Ser_Strobe, bus.Ser_Data, bus.Data_Ready, bus.Busy, bus.Done};
        if (Reset !== 1'b1) begin
            e = '0;
            last_data = 1'b0;
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            last_data = e.data;
        end else begin
            e = exp_t'{1'b0, last_data, 1'b0, 1'b0, 1'b0};
        end
        check("cycle{strobe,data,ready,busy,done}", a, e);
        if (a.strobe && !prev_strobe) rx_q.push_back(a.data);
        prev_strobe = a.strobe;
        if (a.done) done_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clk);
            bus.Start      = 1'b0;
            bus.Data_Valid = 1'b0;
        end
    endtask

    // Drive one frame cycle by cycle. Inputs for edge k+t are set on the
    // falling edge before it. busy_start_t pulses a stray Start with a zero
    // header; abort_t asserts reset 3 time units after edge k+abort_t.
    task automatic run_frame(input logic [W-1:0] hdr, input logic has_pl,
                             input logic [W-1:0] w0, input logic [W-1:0] w1,
                             input int g0, input int g1,
                             input int busy_start_t, input int abort_t);
        exp_t         q[$];
        logic [W-1:0] pl [FL];
        int           gap [FL];
        int           hs [FL];
        int           last_t;
        pl[0] = w0; pl[1] = w1;
        gap[0] = g0; gap[1] = g1;
        build_frame(hdr, has_pl, pl, gap, q);
        last_t = q.size() - 1;
        hs[0] = WORD_CYC + 1 + g0;
        hs[1] = hs[0] + WORD_CYC + 1 + g1;
        for (int t = 0; t <= last_t + 1; t++) begin
            int p;
            @(negedge Clk);
            if (t == 0) foreach (q[i]) exp_q.push_back(q[i]);
            bus.Start       = (t == 0) || (t == busy_start_t);
            bus.Header      = (t == 0) ? hdr : ((t == busy_start_t) ? '0 : ~hdr);
            bus.Has_Payload = (t == 0) ? has_pl : ~has_pl;
            p = (has_pl && t > hs[0]) ? 1 : 0;
            bus.Data_In     = pl[p];
            bus.Data_Valid  = !(has_pl && (t > hs[p] - 1 - gap[p]) && (t < hs[p]));
            if (t == abort_t) begin
                @(posedge Clk);
                #3;
                Reset = 1'b0;
                #1;
                check("abort_strobe", bus.Ser_Strobe, 0);
                check("abort_busy", bus.Busy, 0);
                check("abort_all_outputs",
                      {bus.Ser_Strobe, bus.Ser_Data, bus.Data_Ready, bus.Busy, bus.Done}, 0);
                bus.Start      = 1'b0;
                bus.Data_Valid = 1'b0;
                repeat (2) @(negedge Clk);
                Reset = 1'b1;
                return;
            end
        end
    endtask

    task automatic check_rx(input string name, input int start, input int n, input logic [31:0] expv);
        logic [31:0] v = '0;
        int          avail;
        avail = rx_q.size() - start;
        check({name, "_count"}, avail, n);
        for (int i = 0; i < n && i < avail; i++) v = {v[30:0], rx_q[start + i]};
        check(name, v, expv);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t         tq[$];
        logic [W-1:0] pl [FL];
        int           gap [FL];
        int           s;
        int           d;

        bus.Start = 1'b0; bus.Header = '0; bus.Has_Payload = 1'b0;
        bus.Data_In = '0; bus.Data_Valid = 1'b0;
        Reset = 1'b0;

        #12;
        check("reset_outputs",
              {bus.Ser_Strobe, bus.Ser_Data, bus.Data_Ready, bus.Busy, bus.Done}, 0);
        @(negedge Clk);
        Reset = 1'b1;
        idle(3);

        // Pin the model with hand-computed trace entries.
        pl[0] = 8'hFF; pl[1] = 8'h01; gap[0] = 0; gap[1] = 0;
        build_frame(8'hA5, 1'b0, pl, gap, tq);
        check("model_hdr_len", tq.size(), 33);
        check("model_hdr_bit2_high", tq[8], 5'b11010);
        check("model_hdr_last_low", tq[31], 5'b01010);
        check("model_hdr_done", tq[32], 5'b01011);
        build_frame(8'h3C, 1'b1, pl, gap, tq);
        check("model_full_len", tq.size(), 99);
        check("model_full_wait0", tq[32], 5'b00110);
        check("model_full_w0_msb", tq[33], 5'b11010);
        check("model_full_w1_msb", tq[66], 5'b10010);
        check("model_full_done", tq[98], 5'b01011);

        // Header-only frame.
        s = rx_q.size(); d = done_cnt;
        run_frame(8'hA5, 1'b0, 8'h00, 8'h00, 0, 0, -1, -1);
        check_rx("hdr_only_bits", s, 8, 32'hA5);
        check("hdr_only_done", done_cnt - d, 1);
        idle(2);

        // Full frame with Data_Valid held high.
        s = rx_q.size(); d = done_cnt;
        run_frame(8'h3C, 1'b1, 8'hFF, 8'h01, 0, 0, -1, -1);
        check_rx("full_bits", s, 24, 32'h3CFF01);
        check("full_done", done_cnt - d, 1);
        idle(2);

        // Long stall before the first payload word.
        s = rx_q.size(); d = done_cnt;
        run_frame(8'h96, 1'b1, 8'h5A, 8'hC3, 50, 0, -1, -1);
        check_rx("stall_bits", s, 24, 32'h965AC3);
        check("stall_done", done_cnt - d, 1);
        idle(2);

        // Stray Start with a zero header while busy.
        s = rx_q.size(); d = done_cnt;
        run_frame(8'hB4, 1'b0, 8'h00, 8'h00, 0, 0, 5, -1);
        check_rx("busy_start_bits", s, 8, 32'hB4);
        check("busy_start_done", done_cnt - d, 1);
        idle(2);

        // Reset during the third strobe high phase, then stay idle.
        s = rx_q.size(); d = done_cnt;
        run_frame(8'hE7, 1'b1, 8'h12, 8'h34, 0, 0, -1, 8);
        idle(10);
        check_rx("abort_bits", s, 3, 32'h7);
        check("abort_no_done", done_cnt - d, 0);

        // Back-to-back frames: second Start in the cycle after Done.
        s = rx_q.size(); d = done_cnt;
        run_frame(8'h81, 1'b0, 8'h00, 8'h00, 0, 0, -1, -1);
        run_frame(8'h7E, 1'b0, 8'h00, 8'h00, 0, 0, -1, -1);
        check_rx("b2b_bits", s, 16, 32'h817E);
        check("b2b_done", done_cnt - d, 2);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
